// File: rtl/crddrop_flex.sv
// crddrop_flex: coordinate-drop stage for the sparse streaming datapath.
// Removes outer coordinates whose inner fiber is empty and repairs the inner
// stop-token hierarchy so that absorbed stops reappear as one merged stop.
// A bypass mode passes both streams straight through.

// Small synchronous FIFO used as the input buffer on each channel.
module crddrop_flex_fifo #(
  parameter int W     = 17,
  parameter int DEPTH = 4
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_clk_en,
  input  logic         i_flush,
  input  logic         i_push,
  input  logic [W-1:0] i_data,
  input  logic         i_pop,
  output logic [W-1:0] o_head,
  output logic         o_empty,
  output logic         o_full
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] r_mem [DEPTH];
  logic [AW:0]  r_wp;
  logic [AW:0]  r_rp;

  // Pointer update; the extra MSB distinguishes full from empty.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wp <= '0;
      r_rp <= '0;
    end else if (i_clk_en) begin
      if (i_flush) begin
        r_wp <= '0;
        r_rp <= '0;
      end else begin
        if (i_push) r_wp <= r_wp + 1'b1;
        if (i_pop)  r_rp <= r_rp + 1'b1;
      end
    end
  end

  // Storage array, not reset: contents are only visible through the pointers.
  always_ff @(posedge i_clk) begin
    if (i_clk_en && !i_flush && i_push) r_mem[r_wp[AW-1:0]] <= i_data;
  end

  assign o_head  = r_mem[r_rp[AW-1:0]];
  assign o_empty = (r_wp == r_rp);
  assign o_full  = (r_wp[AW-1:0] == r_rp[AW-1:0]) && (r_wp[AW] != r_rp[AW]);
endmodule

// Top: two input FIFOs, the drop FSM and one holding register per output.
module crddrop_flex #(
  parameter int DATA_W     = 16,
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = 16
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_clk_en,
  input  logic              i_flush,
  input  logic              i_tile_en,
  input  logic              i_cfg_mode,
  input  logic [DATA_W:0]   i_outer_in,
  input  logic              i_outer_in_valid,
  output logic              o_outer_in_ready,
  input  logic [DATA_W:0]   i_inner_in,
  input  logic              i_inner_in_valid,
  output logic              o_inner_in_ready,
  output logic [DATA_W:0]   o_outer_out,
  output logic              o_outer_out_valid,
  input  logic              i_outer_out_ready,
  output logic [DATA_W:0]   o_inner_out,
  output logic              o_inner_out_valid,
  input  logic              i_inner_out_ready,
  output logic [CNT_W-1:0]  o_dropped_count,
  output logic              o_protocol_err
);
  localparam int W = DATA_W + 1;

  typedef enum logic [1:0] {ST_OUTER, ST_INNER, ST_DRAIN} state_t;

  state_t       r_state;
  logic [W-1:0] r_hold;
  logic         r_nonempty;
  logic         r_pend_v;
  logic [7:0]   r_pend_lvl;
  logic [W-1:0] r_oo;
  logic         r_oo_v;
  logic [W-1:0] r_io;
  logic         r_io_v;
  logic [CNT_W-1:0] r_cnt;
  logic         r_err;

  logic [W-1:0] w_oh, w_ih;
  logic         w_of_empty, w_of_full, w_if_empty, w_if_full;
  logic         w_oi_push, w_ii_push;
  logic         w_pop_o, w_pop_i;
  logic         w_ld_oo, w_ld_io;
  logic [W-1:0] w_oo_d, w_io_d;
  logic         w_oo_take, w_io_take, w_oo_free, w_io_free;
  logic         w_ev_hold, w_ev_to_drain, w_ev_first, w_ev_istop;
  logic         w_ev_err, w_ev_done, w_pend_clr;
  logic [W-1:0] w_pend_tok;
  logic [7:0]   w_lvl_max;

  assign o_outer_in_ready = !w_of_full && i_tile_en && i_clk_en && !i_rst;
  assign o_inner_in_ready = !w_if_full && i_tile_en && i_clk_en && !i_rst;
  assign w_oi_push = i_outer_in_valid && o_outer_in_ready;
  assign w_ii_push = i_inner_in_valid && o_inner_in_ready;

  crddrop_flex_fifo #(.W(W), .DEPTH(FIFO_DEPTH)) u_ofifo (
    .i_clk(i_clk), .i_rst(i_rst), .i_clk_en(i_clk_en), .i_flush(i_flush),
    .i_push(w_oi_push), .i_data(i_outer_in), .i_pop(w_pop_o),
    .o_head(w_oh), .o_empty(w_of_empty), .o_full(w_of_full)
  );

  crddrop_flex_fifo #(.W(W), .DEPTH(FIFO_DEPTH)) u_ififo (
    .i_clk(i_clk), .i_rst(i_rst), .i_clk_en(i_clk_en), .i_flush(i_flush),
    .i_push(w_ii_push), .i_data(i_inner_in), .i_pop(w_pop_i),
    .o_head(w_ih), .o_empty(w_if_empty), .o_full(w_if_full)
  );

  assign o_outer_out       = r_oo;
  assign o_outer_out_valid = r_oo_v && i_tile_en;
  assign o_inner_out       = r_io;
  assign o_inner_out_valid = r_io_v && i_tile_en;
  assign o_dropped_count   = r_cnt;
  assign o_protocol_err    = r_err;

  // A register counts as free when empty or being drained this cycle.
  assign w_oo_take  = r_oo_v && i_outer_out_ready && i_tile_en;
  assign w_io_take  = r_io_v && i_inner_out_ready && i_tile_en;
  assign w_oo_free  = !r_oo_v || w_oo_take;
  assign w_io_free  = !r_io_v || w_io_take;
  assign w_pend_tok = {1'b1, {(DATA_W-8){1'b0}}, r_pend_lvl};
  assign w_lvl_max  = (r_pend_v && (r_pend_lvl > w_ih[7:0])) ? r_pend_lvl : w_ih[7:0];

  // Decide this cycle's pops, output loads and FSM events from the FIFO heads.
  always_comb begin
    w_pop_o = 1'b0;  w_pop_i = 1'b0;
    w_ld_oo = 1'b0;  w_ld_io = 1'b0;
    w_oo_d  = w_oh;  w_io_d  = w_ih;
    w_ev_hold = 1'b0;  w_ev_to_drain = 1'b0;  w_ev_first = 1'b0;
    w_ev_istop = 1'b0; w_ev_err = 1'b0;       w_ev_done = 1'b0;
    w_pend_clr = 1'b0;
    if (i_tile_en) begin
      if (i_cfg_mode) begin
        if (!w_of_empty && w_oo_free) begin w_ld_oo = 1'b1; w_pop_o = 1'b1; end
        if (!w_if_empty && w_io_free) begin w_ld_io = 1'b1; w_pop_i = 1'b1; end
      end else begin
        case (r_state)
          ST_OUTER: if (!w_of_empty) begin
            if (!w_oh[DATA_W]) begin
              w_ev_hold = 1'b1;
              w_pop_o   = 1'b1;
            end else if (w_oh[8]) begin
              w_ev_to_drain = 1'b1;
            end else if (w_oo_free) begin
              w_ld_oo = 1'b1;
              w_pop_o = 1'b1;
            end
          end
          ST_INNER: if (!w_if_empty) begin
            if (!w_ih[DATA_W]) begin
              if (r_nonempty) begin
                if (w_io_free) begin w_ld_io = 1'b1; w_pop_i = 1'b1; end
              end else if (r_pend_v) begin
                if (w_io_free) begin
                  w_ld_io = 1'b1; w_io_d = w_pend_tok; w_pend_clr = 1'b1;
                end
              end else if (w_oo_free && w_io_free) begin
                w_ld_oo = 1'b1; w_oo_d = r_hold;
                w_ld_io = 1'b1; w_pop_i = 1'b1; w_ev_first = 1'b1;
              end
            end else if (w_ih[8]) begin
              // Inner done with an outer coordinate still open: abandon it.
              w_ev_to_drain = 1'b1;
            end else begin
              w_ev_istop = 1'b1;
              w_pop_i    = 1'b1;
            end
          end
          ST_DRAIN: if (!w_if_empty) begin
            if (!(w_ih[DATA_W] && w_ih[8])) begin
              w_ev_err = 1'b1;
              w_pop_i  = 1'b1;
            end else if (r_pend_v) begin
              if (w_io_free) begin
                w_ld_io = 1'b1; w_io_d = w_pend_tok; w_pend_clr = 1'b1;
              end
            end else if (w_oo_free && w_io_free && !w_of_empty) begin
              w_ld_oo = 1'b1; w_ld_io = 1'b1;
              w_pop_o = 1'b1; w_pop_i = 1'b1; w_ev_done = 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  // FSM state, pending stop, output registers, drop counter and error flag.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= ST_OUTER;  r_hold <= '0;  r_nonempty <= 1'b0;
      r_pend_v <= 1'b0;     r_pend_lvl <= '0;
      r_oo <= '0;  r_oo_v <= 1'b0;  r_io <= '0;  r_io_v <= 1'b0;
      r_cnt <= '0; r_err <= 1'b0;
    end else if (i_clk_en) begin
      if (i_flush) begin
        r_state <= ST_OUTER;  r_hold <= '0;  r_nonempty <= 1'b0;
        r_pend_v <= 1'b0;     r_pend_lvl <= '0;
        r_oo <= '0;  r_oo_v <= 1'b0;  r_io <= '0;  r_io_v <= 1'b0;
        r_cnt <= '0; r_err <= 1'b0;
      end else begin
        if (w_ld_oo) begin
          r_oo <= w_oo_d;  r_oo_v <= 1'b1;
        end else if (w_oo_take) begin
          r_oo_v <= 1'b0;
        end
        if (w_ld_io) begin
          r_io <= w_io_d;  r_io_v <= 1'b1;
        end else if (w_io_take) begin
          r_io_v <= 1'b0;
        end
        if (!i_tile_en || i_cfg_mode) begin
          r_state <= ST_OUTER;
        end else begin
          case (r_state)
            ST_OUTER: begin
              if (w_ev_hold) begin
                r_hold <= w_oh;  r_nonempty <= 1'b0;  r_state <= ST_INNER;
              end else if (w_ev_to_drain) begin
                r_state <= ST_DRAIN;
              end
            end
            ST_INNER: begin
              if (w_pend_clr) r_pend_v <= 1'b0;
              if (w_ev_first) r_nonempty <= 1'b1;
              if (w_ev_to_drain) r_state <= ST_DRAIN;
              if (w_ev_istop) begin
                r_state <= ST_OUTER;
                if (r_nonempty) begin
                  r_pend_v <= 1'b1;  r_pend_lvl <= w_ih[7:0];
                end else begin
                  if (r_cnt != {CNT_W{1'b1}}) r_cnt <= r_cnt + 1'b1;
                  if (w_ih[7:0] != 8'd0) begin
                    r_pend_v <= 1'b1;  r_pend_lvl <= w_lvl_max;
                  end
                end
              end
            end
            ST_DRAIN: begin
              if (w_ev_err) r_err <= 1'b1;
              if (w_pend_clr) r_pend_v <= 1'b0;
              if (w_ev_done) begin
                r_pend_v <= 1'b0;  r_state <= ST_OUTER;
              end
            end
            default: r_state <= ST_OUTER;
          endcase
        end
      end
    end
  end
endmodule

// File: tb/tb_crddrop_flex.sv
// Testbench for crddrop_flex: directed scenarios plus randomized tiles checked
// against a fiber-level reference model through output scoreboards.
module tb_crddrop_flex;
  localparam int DATA_W = 16;
  localparam int FIFO_DEPTH = 4;
  localparam int CNT_W = 3;
  localparam int W = DATA_W + 1;
  localparam logic [W-1:0] TD  = 17'h10100;
  localparam logic [W-1:0] TS0 = 17'h10000;
  localparam logic [W-1:0] TS1 = 17'h10001;

  logic i_clk, i_rst, i_clk_en, i_flush, i_tile_en, i_cfg_mode;
  logic [W-1:0] i_outer_in, i_inner_in, o_outer_out, o_inner_out;
  logic i_outer_in_valid, o_outer_in_ready, i_inner_in_valid, o_inner_in_ready;
  logic o_outer_out_valid, i_outer_out_ready, o_inner_out_valid, i_inner_out_ready;
  logic [CNT_W-1:0] o_dropped_count;
  logic o_protocol_err;

  crddrop_flex #(.DATA_W(DATA_W), .FIFO_DEPTH(FIFO_DEPTH), .CNT_W(CNT_W)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_clk_en(i_clk_en), .i_flush(i_flush),
    .i_tile_en(i_tile_en), .i_cfg_mode(i_cfg_mode),
    .i_outer_in(i_outer_in), .i_outer_in_valid(i_outer_in_valid), .o_outer_in_ready(o_outer_in_ready),
    .i_inner_in(i_inner_in), .i_inner_in_valid(i_inner_in_valid), .o_inner_in_ready(o_inner_in_ready),
    .o_outer_out(o_outer_out), .o_outer_out_valid(o_outer_out_valid), .i_outer_out_ready(i_outer_out_ready),
    .o_inner_out(o_inner_out), .o_inner_out_valid(o_inner_out_valid), .i_inner_out_ready(i_inner_out_ready),
    .o_dropped_count(o_dropped_count), .o_protocol_err(o_protocol_err)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  int checks = 0;
  int errors = 0;
  logic [W-1:0] src_o[$], src_i[$], drv_o[$], drv_i[$], exp_o[$], exp_i[$];
  int exp_cnt;
  bit exp_err;
  bit run_drv, rnd_in, rnd_out, rnd_ce, hold_oo;

  function automatic logic [W-1:0] stop_tok(input int l);
    return {1'b1, 8'h00, l[7:0]};
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, req);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #3;
  endtask

  // Input drivers and output-ready generator, updated just after each edge.
  initial begin
    forever begin
      @(posedge i_clk);
      #1;
      i_outer_in_valid  = run_drv && drv_o.size() > 0 && (!rnd_in || $urandom_range(0, 3) != 0);
      i_outer_in        = (drv_o.size() > 0) ? drv_o[0] : '0;
      i_inner_in_valid  = run_drv && drv_i.size() > 0 && (!rnd_in || $urandom_range(0, 3) != 0);
      i_inner_in        = (drv_i.size() > 0) ? drv_i[0] : '0;
      i_outer_out_ready = !hold_oo && (!rnd_out || $urandom_range(0, 3) != 0);
      i_inner_out_ready = !rnd_out || $urandom_range(0, 3) != 0;
      i_clk_en          = !rnd_ce || $urandom_range(0, 9) != 0;
    end
  end

  // Monitor: retires accepted inputs and scores every output handshake.
  initial begin
    forever begin
      @(negedge i_clk);
      if (!i_rst && i_clk_en) begin
        if (o_outer_out_valid && i_outer_out_ready) begin
          if (exp_o.size() == 0) begin
            checks++; errors++;
            $display("FAIL outer_out_extra: got %0h expected no token", o_outer_out);
          end else check("outer_out", o_outer_out, exp_o.pop_front());
        end
        if (o_inner_out_valid && i_inner_out_ready) begin
          if (exp_i.size() == 0) begin
            checks++; errors++;
            $display("FAIL inner_out_extra: got %0h expected no token", o_inner_out);
          end else check("inner_out", o_inner_out, exp_i.pop_front());
        end
        if (i_outer_in_valid && o_outer_in_ready) void'(drv_o.pop_front());
        if (i_inner_in_valid && o_inner_in_ready) void'(drv_i.pop_front());
      end
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: time limit reached, got %0d errors so far", errors);
    $fatal(1, "watchdog");
  end

  // Fiber-level reference: walk outer tokens, consume each coordinate's whole
  // inner fiber at once, and track the one merged stop that is still owed.
  task automatic model_drop();
    int ii = 0;
    bit pv = 0;
    int pl = 0;
    int cnt = 0;
    int j;
    logic [W-1:0] fib[$];
    exp_o = {}; exp_i = {}; exp_err = 0;
    foreach (src_o[k]) begin
      if (!src_o[k][16]) begin
        fib = {};
        while (ii < src_i.size() && !src_i[ii][16]) begin fib.push_back(src_i[ii]); ii++; end
        j = int'(src_i[ii][7:0]);
        ii++;
        if (fib.size() > 0) begin
          if (pv) exp_i.push_back(stop_tok(pl));
          exp_o.push_back(src_o[k]);
          foreach (fib[f]) exp_i.push_back(fib[f]);
          pv = 1; pl = j;
        end else begin
          cnt++;
          if (j > 0) begin
            pl = (pv && pl > j) ? pl : j;
            pv = 1;
          end
        end
      end else if (!src_o[k][8]) begin
        exp_o.push_back(src_o[k]);
      end else begin
        while (ii < src_i.size() && src_i[ii] != TD) begin exp_err = 1; ii++; end
        if (pv) exp_i.push_back(stop_tok(pl));
        exp_o.push_back(TD); exp_i.push_back(TD);
        pv = 0; ii++;
      end
    end
    exp_cnt = (cnt > 7) ? 7 : cnt;
  endtask

  task automatic gen_tile();
    int nseg, nc, nf;
    src_o = {}; src_i = {};
    nseg = $urandom_range(1, 3);
    for (int s = 0; s < nseg; s++) begin
      nc = $urandom_range(0, 4);
      for (int c = 0; c < nc; c++) begin
        src_o.push_back({1'b0, 16'($urandom)});
        nf = $urandom_range(0, 3);
        for (int f = 0; f < nf; f++) src_i.push_back({1'b0, 16'($urandom)});
        src_i.push_back(stop_tok($urandom_range(0, 2)));
      end
      src_o.push_back(stop_tok($urandom_range(0, 1)));
    end
    if ($urandom_range(0, 4) == 0) src_i.push_back({1'b0, 16'($urandom)});
    src_o.push_back(TD);
    src_i.push_back(TD);
  endtask

  task automatic start_tile(input bit mode, input bit ce);
    rnd_ce = 0;
    tick(); tick();
    i_cfg_mode = mode;
    i_flush = 1;
    tick();
    i_flush = 0;
    check("flush_count", o_dropped_count, 0);
    check("flush_err", o_protocol_err, 0);
    drv_o = src_o; drv_i = src_i;
    run_drv = 1;
    rnd_ce = ce;
  endtask

  task automatic finish_tile(input string nm, input int budget);
    int n = 0;
    while ((drv_o.size() + drv_i.size() + exp_o.size() + exp_i.size()) != 0 && n < budget) begin
      tick(); n++;
    end
    run_drv = 0;
    rnd_ce = 0;
    if (n >= budget) begin
      checks++; errors++;
      $display("FAIL %s_timeout: got %0d/%0d tokens outstanding expected 0", nm,
               exp_o.size(), exp_i.size());
      drv_o = {}; drv_i = {}; exp_o = {}; exp_i = {};
      i_rst = 1; tick(); i_rst = 0;
    end else begin
      repeat (3) tick();
      check({nm, "_count"}, o_dropped_count, exp_cnt);
      check({nm, "_err"}, o_protocol_err, exp_err);
    end
  endtask

  task automatic load_basic();
    src_o = {17'h00002, 17'h00005, TS0, TD};
    src_i = {17'h00001, 17'h00003, TS0, TS1, TD};
    exp_o = {17'h00002, TS0, TD};
    exp_i = {17'h00001, 17'h00003, TS1, TD};
    exp_cnt = 1; exp_err = 0;
  endtask

  initial begin
    bit found;
    bit mode;
    i_rst = 1; i_clk_en = 1; i_flush = 0; i_tile_en = 1; i_cfg_mode = 0;
    i_outer_in = '0; i_inner_in = '0; i_outer_in_valid = 0; i_inner_in_valid = 0;
    i_outer_out_ready = 1; i_inner_out_ready = 1;
    run_drv = 0; rnd_in = 0; rnd_out = 0; rnd_ce = 0; hold_oo = 0;
    tick(); tick();
    check("rst_outer_in_ready", o_outer_in_ready, 0);
    check("rst_inner_in_ready", o_inner_in_ready, 0);
    check("rst_outer_out_valid", o_outer_out_valid, 0);
    check("rst_inner_out_valid", o_inner_out_valid, 0);
    check("rst_count", o_dropped_count, 0);
    check("rst_err", o_protocol_err, 0);
    i_rst = 0;
    i_tile_en = 0;
    tick();
    check("tile_off_ready", o_outer_in_ready, 0);
    i_tile_en = 1;
    tick();
    check("tile_on_ready", o_outer_in_ready, 1);

    load_basic();
    start_tile(0, 0);
    finish_tile("drop_basic", 500);

    src_o = {17'h00007, 17'h00008, TS0, TD};
    src_i = {TS0, TS1, TD};
    exp_o = {TS0, TD}; exp_i = {TS1, TD};
    exp_cnt = 2; exp_err = 0;
    start_tile(0, 0);
    finish_tile("all_empty", 500);

    load_basic();
    exp_o = src_o; exp_i = src_i; exp_cnt = 0;
    start_tile(1, 0);
    finish_tile("bypass", 500);

    // Two drop-basic tiles back to back with the outer output stalled.
    load_basic();
    src_o = {src_o, src_o}; src_i = {src_i, src_i};
    exp_o = {exp_o, exp_o}; exp_i = {exp_i, exp_i};
    exp_cnt = 2;
    hold_oo = 1;
    start_tile(0, 0);
    repeat (10) tick();
    check("bp_outer_in_ready", o_outer_in_ready, 0);
    hold_oo = 0;
    finish_tile("backpressure", 500);

    // Reset while the first fiber is in flight, then a clean rerun.
    load_basic();
    start_tile(0, 0);
    found = 0;
    for (int n = 0; n < 50 && !found; n++) begin
      tick();
      if (o_inner_out_valid) found = 1;
    end
    check("rst_mid_seen_inner", found, 1);
    i_rst = 1;
    run_drv = 0;
    drv_o = {}; drv_i = {}; exp_o = {}; exp_i = {};
    tick(); tick();
    check("rst_mid_outer_valid", o_outer_out_valid, 0);
    check("rst_mid_inner_valid", o_inner_out_valid, 0);
    check("rst_mid_ready", o_inner_in_ready, 0);
    check("rst_mid_count", o_dropped_count, 0);
    i_rst = 0;
    load_basic();
    start_tile(0, 0);
    finish_tile("after_reset", 500);

    src_o = {TD};
    src_i = {17'h00004, TD};
    exp_o = {TD}; exp_i = {TD};
    exp_cnt = 0; exp_err = 1;
    start_tile(0, 0);
    finish_tile("proto_err", 500);
    load_basic();
    start_tile(0, 0);
    finish_tile("second_tile", 500);

    // Nine empty fibers saturate a 3-bit counter at 7.
    src_o = {}; src_i = {};
    for (int k = 1; k <= 9; k++) begin
      src_o.push_back(17'(k));
      src_i.push_back(TS0);
    end
    src_o.push_back(TS0); src_o.push_back(TD); src_i.push_back(TD);
    exp_o = {TS0, TD}; exp_i = {TD};
    exp_cnt = 7; exp_err = 0;
    start_tile(0, 0);
    finish_tile("saturate", 500);

    rnd_in = 1; rnd_out = 1;
    for (int t = 0; t < 40; t++) begin
      gen_tile();
      mode = ($urandom_range(0, 3) == 0);
      if (mode) begin
        exp_o = src_o; exp_i = src_i; exp_cnt = 0; exp_err = 0;
      end else begin
        model_drop();
      end
      start_tile(mode, 1);
      finish_tile("random", 3000);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
